// File: rtl/prog_seq_detector_param.sv
// ============================================================================
// prog_seq_detector_param
// ----------------------------------------------------------------------------
// Purpose:
//   Parametrised serial bit-pattern detector. A pattern of 1..SEQ_W bits is
//   programmed at run time with a load strobe. The serial stream is then
//   qualified by din_valid, and a one-cycle 'seen' pulse is raised after each
//   completed occurrence of the pattern. Matching can be overlapping (the
//   tail of one match may start the next) or non-overlapping (each match
//   needs a fresh set of len beats). A saturating counter tracks the number
//   of matches since the last load.
//
// Parameters:
//   SEQ_W  maximum pattern length in bits (>= 2)
//   LEN_W  width of the length field, $clog2(SEQ_W+1)
//   CNT_W  width of the match counter
//
// Ports:
//   clk           in   1      clock, all state changes on the rising edge
//   resetn        in   1      asynchronous active-low reset
//   load          in   1      program strobe: latches pattern, length, mode
//   init_pattern  in   SEQ_W  pattern, bit 0 is the first bit on the stream
//   init_len      in   LEN_W  pattern length in bits (clamped to SEQ_W)
//   overlap       in   1      1 = overlapping matches, 0 = non-overlapping
//   din_valid     in   1      qualifies din
//   din           in   1      serial data bit
//   armed         out  1      a pattern with a non-zero length is programmed
//   seen          out  1      one-cycle pulse, registered, after a match
//   match_count   out  CNT_W  saturating count of matches since load
// ============================================================================
module prog_seq_detector_param #(
    parameter int SEQ_W = 8,
    parameter int LEN_W = $clog2(SEQ_W + 1),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [SEQ_W-1:0] init_pattern,
    input  logic [LEN_W-1:0] init_len,
    input  logic             overlap,
    input  logic             din_valid,
    input  logic             din,
    output logic             armed,
    output logic             seen,
    output logic [CNT_W-1:0] match_count
);

    // Width of an index into the history register.
    localparam int IDX_W = (SEQ_W > 1) ? $clog2(SEQ_W) : 1;

    // Largest legal length and the saturation value of the match counter.
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(SEQ_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t           state;

    // Programmed configuration, captured only on load.
    logic [SEQ_W-1:0] pattern_r;
    logic [LEN_W-1:0] len_r;
    logic             ovl_r;

    // hist[0] is the most recently accepted bit; fill counts how many
    // accepted beats are available to the matcher (saturates at SEQ_W).
    logic [SEQ_W-1:0] hist;
    logic [LEN_W-1:0] fill;

    logic [LEN_W-1:0] len_clamped;
    logic             accept;
    logic [SEQ_W-1:0] hist_next;
    logic [LEN_W:0]   fill_plus1;
    logic             window_ok;
    logic             match;
    logic [IDX_W-1:0] idx;

    // Lengths beyond the history depth cannot be matched, so they are
    // clamped to the deepest window the block can hold.
    always_comb begin
        len_clamped = (init_len > LEN_MAX) ? LEN_MAX : init_len;
    end

    // A beat is accepted only while armed and not loading; a load cycle
    // discards din even when din_valid is high.
    always_comb begin
        accept     = din_valid && (state == ARMED) && !load;
        hist_next  = {hist[SEQ_W-2:0], din};
        fill_plus1 = {1'b0, fill} + (LEN_W + 1)'(1);
    end

    // The window is compared on the post-shift view so that the current
    // din completes the pattern in the same cycle it arrives. Pattern bit i
    // was received (len_r-1-i) beats ago, which is hist_next[len_r-1-i].
    // Pattern bits at or above len_r are ignored.
    always_comb begin
        window_ok = 1'b1;
        idx       = '0;
        for (int i = 0; i < SEQ_W; i++) begin
            if (i < int'(len_r)) begin
                idx = IDX_W'(int'(len_r) - 1 - i);
                if (pattern_r[i] != hist_next[idx]) begin
                    window_ok = 1'b0;
                end
            end
        end
    end

    // A match also needs enough beats in the history: fill counts beats
    // before this one, so the current beat makes it fill+1.
    always_comb begin
        match = accept && (fill_plus1 >= {1'b0, len_r}) && window_ok;
    end

    // Control FSM with all registered outputs. Load wins over everything
    // and restarts matching from an empty history. In non-overlapping mode
    // a match empties fill so the next match needs len_r fresh beats; the
    // history bits themselves are kept but are never looked at until fill
    // has grown back. Cycles without an accepted beat leave hist and fill
    // untouched, so din_valid gaps are invisible to the matcher.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            armed       <= 1'b0;
            seen        <= 1'b0;
            match_count <= '0;
            pattern_r   <= '0;
            len_r       <= '0;
            ovl_r       <= 1'b0;
            hist        <= '0;
            fill        <= '0;
        end else if (load) begin
            pattern_r   <= init_pattern;
            len_r       <= len_clamped;
            ovl_r       <= overlap;
            hist        <= '0;
            fill        <= '0;
            match_count <= '0;
            seen        <= 1'b0;
            if (len_clamped != '0) begin
                state <= ARMED;
                armed <= 1'b1;
            end else begin
                state <= IDLE;
                armed <= 1'b0;
            end
        end else begin
            seen <= match;
            if (accept) begin
                hist <= hist_next;
                if (match && !ovl_r) begin
                    fill <= '0;
                end else if (fill != LEN_MAX) begin
                    fill <= fill + LEN_W'(1);
                end
            end
            if (match && (match_count != CNT_MAX)) begin
                match_count <= match_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_prog_seq_detector_param.sv
// ============================================================================
// tb_prog_seq_detector_param
// ----------------------------------------------------------------------------
// Self-checking bench for prog_seq_detector_param (SEQ_W=8, CNT_W=8).
// Every driven cycle runs a behavioural model that keeps the full list of
// accepted bits since load and pushes the expected seen/armed/match_count
// into a scoreboard queue; each test pops that entry one edge later and
// compares it with the DUT. Directed constant checks back up the model at
// the end of each scenario.
// ============================================================================
module tb_prog_seq_detector_param;

    localparam int SEQ_W = 8;
    localparam int LEN_W = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             resetn;
    logic             load;
    logic [SEQ_W-1:0] init_pattern;
    logic [LEN_W-1:0] init_len;
    logic             overlap;
    logic             din_valid;
    logic             din;
    logic             armed;
    logic             seen;
    logic [CNT_W-1:0] match_count;

    prog_seq_detector_param #(
        .SEQ_W(SEQ_W),
        .LEN_W(LEN_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .load        (load),
        .init_pattern(init_pattern),
        .init_len    (init_len),
        .overlap     (overlap),
        .din_valid   (din_valid),
        .din         (din),
        .armed       (armed),
        .seen        (seen),
        .match_count (match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             seen;
        logic             armed;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];

    int n_tests  = 0;
    int n_failed = 0;

    // Behavioural model state.
    bit               m_armed;
    logic [SEQ_W-1:0] m_pat;
    int               m_len;
    bit               m_ovl;
    bit               m_bits[$];
    int               m_fill;
    int               m_cnt;

    task automatic model_clear();
        m_armed = 0;
        m_pat   = '0;
        m_len   = 0;
        m_ovl   = 0;
        m_bits.delete();
        m_fill  = 0;
        m_cnt   = 0;
        sb.delete();
    endtask

    // Drive one cycle at the falling edge, update the model, push the
    // expectation and return just after the rising edge.
    task automatic step(input bit ld, input logic [SEQ_W-1:0] pat, input int len,
                        input bit ovl, input bit v, input bit d);
        exp_t e;
        bit   hit;
        @(negedge clk);
        load      = ld;
        din_valid = v;
        din       = d;
        if (ld) begin
            init_pattern = pat;
            init_len     = LEN_W'(len);
            overlap      = ovl;
        end else begin
            init_pattern = SEQ_W'($urandom);
            init_len     = LEN_W'($urandom);
            overlap      = 1'($urandom);
        end
        e.seen = 1'b0;
        if (ld) begin
            m_pat   = pat;
            m_len   = (len > SEQ_W) ? SEQ_W : len;
            m_armed = (m_len > 0);
            m_ovl   = ovl;
            m_bits.delete();
            m_fill  = 0;
            m_cnt   = 0;
        end else if (v && m_armed) begin
            m_bits.push_back(d);
            hit = (m_fill + 1 >= m_len);
            if (hit) begin
                for (int i = 0; i < m_len; i++) begin
                    if (m_pat[i] != m_bits[m_bits.size() - m_len + i]) hit = 0;
                end
            end
            if (hit && !m_ovl) m_fill = 0;
            else if (m_fill < SEQ_W) m_fill = m_fill + 1;
            if (hit && m_cnt < 255) m_cnt = m_cnt + 1;
            e.seen = hit;
        end
        e.armed = m_armed;
        e.cnt   = CNT_W'(m_cnt);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        model_clear();
        n_tests++;
        if (armed !== 1'b0 || seen !== 1'b0 || match_count !== '0) begin
            n_failed++;
            $display("[TB] FAIL reset_async: armed/seen/count got %b/%b/%0d want 0/0/0",
                     armed, seen, match_count);
        end
        @(negedge clk);
        load      = 1'b0;
        din_valid = 1'b0;
        din       = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        $display("[TB] test_reset");
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step(0, '0, 0, 0, 1, 1'($urandom));
            e = sb.pop_front();
            n_tests++;
            if (seen !== e.seen || armed !== e.armed || match_count !== e.cnt) begin
                n_failed++;
                $display("[TB] FAIL reset_idle beat %0d: seen/armed/count got %b/%b/%0d want %b/%b/%0d",
                         k, seen, armed, match_count, e.seen, e.armed, e.cnt);
            end
        end
    endtask

    task automatic test_overlap();
        exp_t     e;
        bit [7:0] s = 8'b10101;
        $display("[TB] test_overlap");
        step(1, 8'b101, 3, 1, 1, 1);
        void'(sb.pop_front());
        for (int k = 0; k < 5; k++) begin
            step(0, '0, 0, 0, 1, s[k]);
            e = sb.pop_front();
            n_tests++;
            if (seen !== e.seen || armed !== e.armed || match_count !== e.cnt) begin
                n_failed++;
                $display("[TB] FAIL overlap beat %0d: seen/armed/count got %b/%b/%0d want %b/%b/%0d",
                         k + 1, seen, armed, match_count, e.seen, e.armed, e.cnt);
            end
        end
        n_tests++;
        if (match_count !== 8'd2) begin
            n_failed++;
            $display("[TB] FAIL overlap_count: got %0d want 2", match_count);
        end
    endtask

    task automatic test_nonoverlap();
        exp_t     e;
        bit [7:0] s = 8'b10110101;
        $display("[TB] test_nonoverlap");
        step(1, 8'b101, 3, 0, 1, 1);
        void'(sb.pop_front());
        for (int k = 0; k < 8; k++) begin
            step(0, '0, 0, 0, 1, s[k]);
            e = sb.pop_front();
            n_tests++;
            if (seen !== e.seen || armed !== e.armed || match_count !== e.cnt) begin
                n_failed++;
                $display("[TB] FAIL nonoverlap beat %0d: seen/armed/count got %b/%b/%0d want %b/%b/%0d",
                         k + 1, seen, armed, match_count, e.seen, e.armed, e.cnt);
            end
        end
        n_tests++;
        if (match_count !== 8'd2) begin
            n_failed++;
            $display("[TB] FAIL nonoverlap_count: got %0d want 2", match_count);
        end
    endtask

    task automatic test_gap();
        exp_t     e;
        bit [6:0] v = 7'b1100011;
        bit [6:0] d = 7'b1011111;
        $display("[TB] test_gap");
        step(1, 8'b1011, 4, 1, 0, 0);
        void'(sb.pop_front());
        for (int k = 0; k < 7; k++) begin
            step(0, '0, 0, 0, v[k], d[k]);
            e = sb.pop_front();
            n_tests++;
            if (seen !== e.seen || armed !== e.armed || match_count !== e.cnt) begin
                n_failed++;
                $display("[TB] FAIL gap cycle %0d: seen/armed/count got %b/%b/%0d want %b/%b/%0d",
                         k, seen, armed, match_count, e.seen, e.armed, e.cnt);
            end
        end
        n_tests++;
        if (match_count !== 8'd1) begin
            n_failed++;
            $display("[TB] FAIL gap_count: got %0d want 1", match_count);
        end
    endtask

    task automatic test_back_to_back();
        exp_t     e;
        bit [3:0] s1 = 4'b1011;
        $display("[TB] test_back_to_back");
        // len 1: every beat equal to pattern bit 0 matches, even non-overlapping
        step(1, 8'b1, 1, 0, 0, 0);
        void'(sb.pop_front());
        for (int k = 0; k < 4; k++) begin
            step(0, '0, 0, 0, 1, s1[k]);
            e = sb.pop_front();
            n_tests++;
            if (seen !== e.seen || armed !== e.armed || match_count !== e.cnt) begin
                n_failed++;
                $display("[TB] FAIL len1 beat %0d: seen/armed/count got %b/%b/%0d want %b/%b/%0d",
                         k + 1, seen, armed, match_count, e.seen, e.armed, e.cnt);
            end
        end
        // periodic pattern 11 overlapping: consecutive pulses
        step(1, 8'b11, 2, 1, 1, 1);
        void'(sb.pop_front());
        for (int k = 0; k < 4; k++) begin
            step(0, '0, 0, 0, 1, 1);
            e = sb.pop_front();
            n_tests++;
            if (seen !== e.seen || armed !== e.armed || match_count !== e.cnt) begin
                n_failed++;
                $display("[TB] FAIL b2b beat %0d: seen/armed/count got %b/%b/%0d want %b/%b/%0d",
                         k + 1, seen, armed, match_count, e.seen, e.armed, e.cnt);
            end
        end
        n_tests++;
        if (match_count !== 8'd3 || seen !== 1'b1) begin
            n_failed++;
            $display("[TB] FAIL b2b_count: count/seen got %0d/%b want 3/1", match_count, seen);
        end
    endtask

    task automatic test_saturate_clamp();
        exp_t     e;
        bit [7:0] a5 = 8'hA5;
        bit [7:0] c3 = 8'h3C;
        int       errs = 0;
        $display("[TB] test_saturate_clamp");
        step(1, 8'hA5, 8, 1, 0, 0);
        void'(sb.pop_front());
        for (int r = 0; r < 300; r++) begin
            for (int k = 0; k < 8; k++) begin
                step(0, '0, 0, 0, 1, a5[k]);
                e = sb.pop_front();
                n_tests++;
                if (seen !== e.seen || armed !== e.armed || match_count !== e.cnt) begin
                    n_failed++;
                    errs++;
                    if (errs < 5)
                        $display("[TB] FAIL sat rep %0d beat %0d: seen/count got %b/%0d want %b/%0d",
                                 r, k, seen, match_count, e.seen, e.cnt);
                end
            end
        end
        n_tests++;
        if (match_count !== 8'd255) begin
            n_failed++;
            $display("[TB] FAIL sat_count: got %0d want 255", match_count);
        end
        // New pattern: counter clears, old history must not produce a match
        step(1, 8'h3C, 8, 1, 1, 1);
        void'(sb.pop_front());
        n_tests++;
        if (match_count !== 8'd0 || seen !== 1'b0) begin
            n_failed++;
            $display("[TB] FAIL reload_clear: count/seen got %0d/%b want 0/0", match_count, seen);
        end
        for (int k = 0; k < 8; k++) begin
            step(0, '0, 0, 0, 1, a5[k]);
            e = sb.pop_front();
            n_tests++;
            if (seen !== e.seen || armed !== e.armed || match_count !== e.cnt) begin
                n_failed++;
                $display("[TB] FAIL reload beat %0d: seen/count got %b/%0d want %b/%0d",
                         k, seen, match_count, e.seen, e.cnt);
            end
        end
        // Length 12 clamps to 8
        step(1, 8'h3C, 12, 0, 0, 0);
        void'(sb.pop_front());
        for (int k = 0; k < 8; k++) begin
            step(0, '0, 0, 0, 1, c3[k]);
            e = sb.pop_front();
            n_tests++;
            if (seen !== e.seen || armed !== e.armed || match_count !== e.cnt) begin
                n_failed++;
                $display("[TB] FAIL clamp beat %0d: seen/armed/count got %b/%b/%0d want %b/%b/%0d",
                         k, seen, armed, match_count, e.seen, e.armed, e.cnt);
            end
        end
        n_tests++;
        if (match_count !== 8'd1) begin
            n_failed++;
            $display("[TB] FAIL clamp_count: got %0d want 1", match_count);
        end
        // Length 0 disarms
        step(1, 8'hFF, 0, 1, 0, 0);
        void'(sb.pop_front());
        for (int k = 0; k < 3; k++) begin
            step(0, '0, 0, 0, 1, 1);
            e = sb.pop_front();
            n_tests++;
            if (seen !== e.seen || armed !== e.armed || match_count !== e.cnt) begin
                n_failed++;
                $display("[TB] FAIL len0 beat %0d: seen/armed/count got %b/%b/%0d want %b/%b/%0d",
                         k, seen, armed, match_count, e.seen, e.armed, e.cnt);
            end
        end
    endtask

    task automatic test_reset_midstream();
        exp_t     e;
        bit [3:0] pre  = 4'b0101;
        bit [3:0] post = 4'b1011;
        $display("[TB] test_reset_midstream");
        step(1, 8'b101, 3, 1, 0, 0);
        void'(sb.pop_front());
        for (int k = 0; k < 4; k++) begin
            step(0, '0, 0, 0, 1, pre[k]);
            e = sb.pop_front();
            n_tests++;
            if (seen !== e.seen || armed !== e.armed || match_count !== e.cnt) begin
                n_failed++;
                $display("[TB] FAIL pre_reset beat %0d: seen/count got %b/%0d want %b/%0d",
                         k + 1, seen, match_count, e.seen, e.cnt);
            end
        end
        do_reset();
        step(0, '0, 0, 0, 1, 1);
        e = sb.pop_front();
        n_tests++;
        if (armed !== e.armed || seen !== e.seen) begin
            n_failed++;
            $display("[TB] FAIL disarmed_after_reset: armed/seen got %b/%b want %b/%b",
                     armed, seen, e.armed, e.seen);
        end
        step(1, 8'b101, 3, 1, 0, 0);
        void'(sb.pop_front());
        for (int k = 0; k < 4; k++) begin
            step(0, '0, 0, 0, 1, post[k]);
            e = sb.pop_front();
            n_tests++;
            if (seen !== e.seen || armed !== e.armed || match_count !== e.cnt) begin
                n_failed++;
                $display("[TB] FAIL post_reset beat %0d: seen/count got %b/%0d want %b/%0d",
                         k + 1, seen, match_count, e.seen, e.cnt);
            end
        end
        n_tests++;
        if (match_count !== 8'd1) begin
            n_failed++;
            $display("[TB] FAIL post_reset_count: got %0d want 1", match_count);
        end
    endtask

    initial begin
        resetn       = 1'b0;
        load         = 1'b0;
        init_pattern = '0;
        init_len     = '0;
        overlap      = 1'b0;
        din_valid    = 1'b0;
        din          = 1'b0;
        model_clear();
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_gap();
        test_back_to_back();
        test_saturate_clamp();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
